// File: rtl/sram_like_bus_arbiter_pkg.sv
// rtl/sram_like_bus_arbiter_pkg.sv - shared types, size codes and wen decode for the CPU memory port arbiter
// Contents: bus_state_t FSM encoding, SIZE_* transfer size codes, WEN_W byte-enable width,
//           wen_to_size_off() mapping latched byte enables to {size, addr[1:0]}.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } bus_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int WEN_W = 4;

    // Returns {size[1:0], addr_lo[1:0]}. Reads (wen = 0) and any byte-enable pattern the
    // slave cannot express are issued as aligned word transfers.
    function automatic logic [3:0] wen_to_size_off(input logic [WEN_W-1:0] wen);
        logic [3:0] r;
        case (wen)
            4'b0001: r = {SIZE_BYTE, 2'd0};
            4'b0010: r = {SIZE_BYTE, 2'd1};
            4'b0100: r = {SIZE_BYTE, 2'd2};
            4'b1000: r = {SIZE_BYTE, 2'd3};
            4'b0011: r = {SIZE_HALF, 2'd0};
            4'b1100: r = {SIZE_HALF, 2'd2};
            default: r = {SIZE_WORD, 2'd0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sram_like_bus_arbiter_if.sv
// rtl/sram_like_bus_arbiter_if.sv - CPU channel and sram-like slave signal bundle
// Signals: ch_en/ch_wen/ch_paddr/ch_wdata/pipe_stall (CPU -> arbiter), ch_rdata/ch_stall (arbiter -> CPU),
//          m_req/m_wr/m_size/m_addr/m_wdata (arbiter -> slave), m_addr_ok/m_data_ok/m_rdata (slave -> arbiter).
// Modports: master = arbiter side, slave = CPU/memory environment side.
interface sram_like_bus_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]        ch_en;
    logic [NUM_CH*4-1:0]      ch_wen;
    logic [NUM_CH*ADDR_W-1:0] ch_paddr;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [NUM_CH*DATA_W-1:0] ch_rdata;
    logic [NUM_CH-1:0]        ch_stall;
    logic                     pipe_stall;
    logic                     m_req;
    logic                     m_wr;
    logic [1:0]               m_size;
    logic [ADDR_W-1:0]        m_addr;
    logic [DATA_W-1:0]        m_wdata;
    logic                     m_addr_ok;
    logic                     m_data_ok;
    logic [DATA_W-1:0]        m_rdata;

    modport master (
        input  ch_en, ch_wen, ch_paddr, ch_wdata, pipe_stall, m_addr_ok, m_data_ok, m_rdata,
        output ch_rdata, ch_stall, m_req, m_wr, m_size, m_addr, m_wdata
    );

    modport slave (
        output ch_en, ch_wen, ch_paddr, ch_wdata, pipe_stall, m_addr_ok, m_data_ok, m_rdata,
        input  ch_rdata, ch_stall, m_req, m_wr, m_size, m_addr, m_wdata
    );
endinterface

// File: rtl/sram_like_bus_arbiter_grant.sv
// rtl/sram_like_bus_arbiter_grant.sv - one-hot grant selection among pending CPU channels
// Ports: en (grant allowed this cycle), pending[NUM_CH] in; grant[NUM_CH] one-hot out (zero when !en or none pending).
//        clk/rst exist only with ARB_ROUND_ROBIN_EN, which enables the last_grant pointer (reset 0) and
//        starts the search at last_grant+1 mod NUM_CH; otherwise fixed priority, highest index wins.
module bus_grant_arbiter #(
    parameter int NUM_CH = 2
) (
`ifdef ARB_ROUND_ROBIN_EN
    input  logic              clk,
    input  logic              rst,
`endif
    input  logic              en,
    input  logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] grant
);

`ifdef ARB_ROUND_ROBIN_EN
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PTR_W-1:0] last_grant;
    logic [PTR_W-1:0] next_grant;

    // Walk downward so the last match written is the one closest after last_grant.
    always_comb begin
        int idx;
        idx        = 0;
        grant      = '0;
        next_grant = last_grant;
        if (en) begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                idx = (int'(last_grant) + 1 + k) % NUM_CH;
                if (pending[idx]) begin
                    grant      = '0;
                    grant[idx] = 1'b1;
                    next_grant = PTR_W'(idx);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= '0;
        end else if (|grant) begin
            last_grant <= next_grant;
        end
    end
`else
    // Upward walk: the highest pending index overwrites any lower one.
    always_comb begin
        grant = '0;
        if (en) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (pending[k]) begin
                    grant    = '0;
                    grant[k] = 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: rtl/sram_like_bus_arbiter.sv
// rtl/sram_like_bus_arbiter.sv - shares one sram-like slave port among NUM_CH SRAM-style CPU channels
// Ports: clk, rst (synchronous, active-high); bus (master modport): ch_en/ch_wen/ch_paddr/ch_wdata/pipe_stall in,
//        ch_rdata/ch_stall out, m_req/m_wr/m_size/m_addr/m_wdata out, m_addr_ok/m_data_ok/m_rdata in.
// Config: ARB_ROUND_ROBIN_EN selects round-robin grant; default is fixed priority (highest index wins).
module sram_like_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_like_bus_arbiter_if.master bus
);

    localparam int GI_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    bus_state_t        state, state_n;
    logic [NUM_CH-1:0] done, done_n;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] grant;
    logic              arb_en;
    logic              capture;

    logic [GI_W-1:0]   gnt_idx, sel_idx;
    logic [WEN_W-1:0]  sel_wen;
    logic [ADDR_W-1:0] sel_paddr;
    logic [DATA_W-1:0] sel_wdata;
    logic [3:0]        size_off;

    logic              req_wr;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] rdata_q [NUM_CH];

    // A served channel stays masked by done until the pipe advances, so it is not reissued.
    assign pending      = bus.ch_en & ~done;
    assign bus.ch_stall = pending;
    assign arb_en       = (state == IDLE);

    bus_grant_arbiter #(.NUM_CH(NUM_CH)) u_grant (
`ifdef ARB_ROUND_ROBIN_EN
        .clk     (clk),
        .rst     (rst),
`endif
        .en      (arb_en),
        .pending (pending),
        .grant   (grant)
    );

    always_comb begin
        sel_wen   = '0;
        sel_paddr = '0;
        sel_wdata = '0;
        sel_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant[k]) begin
                sel_wen   = bus.ch_wen[k*WEN_W +: WEN_W];
                sel_paddr = bus.ch_paddr[k*ADDR_W +: ADDR_W];
                sel_wdata = bus.ch_wdata[k*DATA_W +: DATA_W];
                sel_idx   = GI_W'(k);
            end
        end
    end

    assign size_off = wen_to_size_off(sel_wen);

    // Next state. data_ok is only meaningful once the address has been accepted.
    always_comb begin
        state_n = state;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (|pending) state_n = ADDR;
            end
            ADDR: begin
                if (bus.m_addr_ok) begin
                    if (bus.m_data_ok) begin
                        capture = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                    end
                end
            end
            DATA: begin
                if (bus.m_data_ok) begin
                    capture = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Completion sets done even if the pipe is released in the same cycle.
    always_comb begin
        done_n = bus.pipe_stall ? done : '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (capture && (gnt_idx == GI_W'(k))) done_n[k] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            done      <= '0;
            gnt_idx   <= '0;
            req_wr    <= 1'b0;
            req_size  <= SIZE_BYTE;
            req_addr  <= '0;
            req_wdata <= '0;
            for (int k = 0; k < NUM_CH; k++) rdata_q[k] <= '0;
        end else begin
            state <= state_n;
            done  <= done_n;
            if (|grant) begin
                gnt_idx   <= sel_idx;
                req_wr    <= |sel_wen;
                req_size  <= size_off[3:2];
                req_addr  <= (sel_paddr & ~ADDR_W'(3)) | ADDR_W'(size_off[1:0]);
                req_wdata <= sel_wdata;
            end
            if (capture && !req_wr) rdata_q[gnt_idx] <= bus.m_rdata;
        end
    end

    assign bus.m_req   = (state == ADDR);
    assign bus.m_wr    = req_wr;
    assign bus.m_size  = req_size;
    assign bus.m_addr  = req_addr;
    assign bus.m_wdata = req_wdata;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_rdata
        assign bus.ch_rdata[g*DATA_W +: DATA_W] = rdata_q[g];
    end

endmodule

// File: tb/tb_sram_like_bus_arbiter.sv
// tb/tb_sram_like_bus_arbiter.sv - scoreboard bench for sram_like_bus_arbiter with a latency-programmable slave
module tb_sram_like_bus_arbiter;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          ch;
        logic [31:0] data;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    logic hold_stall;

    always #5 clk = ~clk;

    sram_like_bus_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    assign bus.pipe_stall = (|bus.ch_stall) | hold_stall;

    sram_like_bus_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    req_t        exp_req_q[$];
    res_t        exp_res_q[$];
    logic [31:0] model_rd [NUM_CH];
    int          n_checks   = 0;
    int          n_errors   = 0;
    int          accept_cnt = 0;
    int          addr_lat   = 0;
    int          data_lat   = 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        if (a == 32'h1FC0_0000) return 32'hDEAD_BEEF;
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Slave: addr_ok after addr_lat cycles of m_req, data_ok data_lat cycles after acceptance (0 = same cycle).
    initial begin
        int          sl_phase;
        int          sl_cnt;
        logic [31:0] sl_addr;
        sl_phase      = 0;
        sl_cnt        = 0;
        sl_addr       = '0;
        bus.m_addr_ok = 1'b0;
        bus.m_data_ok = 1'b0;
        bus.m_rdata   = '0;
        forever begin
            @(posedge clk);
            #2;
            bus.m_addr_ok = 1'b0;
            bus.m_data_ok = 1'b0;
            if (rst) begin
                sl_phase = 0;
                sl_cnt   = 0;
            end else if (sl_phase == 0) begin
                if (bus.m_req) begin
                    if (sl_cnt >= addr_lat) begin
                        bus.m_addr_ok = 1'b1;
                        sl_addr       = bus.m_addr;
                        sl_cnt        = 0;
                        if (data_lat == 0) begin
                            bus.m_data_ok = 1'b1;
                            bus.m_rdata   = rd_of(bus.m_addr);
                        end else begin
                            sl_phase = 1;
                            sl_cnt   = 1;
                        end
                    end else begin
                        sl_cnt++;
                    end
                end
            end else begin
                if (sl_cnt >= data_lat) begin
                    bus.m_data_ok = 1'b1;
                    bus.m_rdata   = rd_of(sl_addr);
                    sl_phase      = 0;
                    sl_cnt        = 0;
                end else begin
                    sl_cnt++;
                end
            end
        end
    end

    // Monitors: accepted requests and completed channel accesses are popped from the scoreboard.
    initial begin
        logic [NUM_CH-1:0] prev_stall;
        req_t r;
        res_t s;
        prev_stall = '0;
        forever begin
            @(negedge clk);
            if (!rst && bus.m_req && bus.m_addr_ok) begin
                accept_cnt++;
                if (exp_req_q.size() == 0) begin
                    check("req_queue_size", exp_req_q.size(), 1);
                end else begin
                    r = exp_req_q.pop_front();
                    check("req_wr", bus.m_wr, r.wr);
                    check("req_size", bus.m_size, r.size);
                    check("req_addr", bus.m_addr, r.addr);
                    check("req_wdata", bus.m_wdata, r.wdata);
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (!rst && prev_stall[i] && !bus.ch_stall[i] && bus.ch_en[i]) begin
                    if (exp_res_q.size() == 0) begin
                        check("res_queue_size", exp_res_q.size(), 1);
                    end else begin
                        s = exp_res_q.pop_front();
                        check("res_ch", i, s.ch);
                        check("res_rdata", bus.ch_rdata[i*DATA_W +: DATA_W], s.data);
                    end
                end
            end
            prev_stall = bus.ch_stall;
        end
    end

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    // Drives one channel's request and pushes its expected slave request and completion result.
    task automatic push_access(input int ch, input logic [3:0] wen, input logic [31:0] paddr,
                               input logic [31:0] wdata);
        req_t       r;
        res_t       s;
        logic [1:0] size;
        logic [1:0] lo;
        size = 2'd2;
        lo   = 2'd0;
        if (wen == 4'b0011) begin
            size = 2'd1;
            lo   = 2'd0;
        end else if (wen == 4'b1100) begin
            size = 2'd1;
            lo   = 2'd2;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (wen == (4'b0001 << b)) begin
                    size = 2'd0;
                    lo   = 2'(b);
                end
            end
        end
        r.wr    = (wen != 4'b0000);
        r.size  = size;
        r.addr  = {paddr[31:2], lo};
        r.wdata = wdata;
        exp_req_q.push_back(r);
        s.ch = ch;
        if (r.wr) begin
            s.data = model_rd[ch];
        end else begin
            s.data       = rd_of(r.addr);
            model_rd[ch] = s.data;
        end
        exp_res_q.push_back(s);
        bus.ch_en[ch]             = 1'b1;
        bus.ch_wen[ch*4 +: 4]     = wen;
        bus.ch_paddr[ch*32 +: 32] = paddr;
        bus.ch_wdata[ch*32 +: 32] = wdata;
    endtask

    // Single-channel access with latency check; keep leaves ch_en asserted afterwards.
    task automatic single(input int ch, input logic [3:0] wen, input logic [31:0] paddr,
                          input logic [31:0] wdata, input int alat, input int dlat, input bit keep);
        int n;
        addr_lat = alat;
        data_lat = dlat;
        cyc1();
        push_access(ch, wen, paddr, wdata);
        #1;
        check("stall_rise", bus.ch_stall[ch], 1);
        n = 0;
        do begin
            cyc1();
            n++;
        end while (bus.ch_stall[ch] && n < 40);
        check("stall_latency", n, 2 + alat + dlat);
        check("stall_low", bus.ch_stall[ch], 0);
        if (!keep) begin
            cyc1();
            bus.ch_en[ch] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int  n;
        int  base;
        bit  seen1;
        rst          = 1'b1;
        hold_stall   = 1'b0;
        bus.ch_en    = '0;
        bus.ch_wen   = '0;
        bus.ch_paddr = '0;
        bus.ch_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) model_rd[i] = '0;
        repeat (3) cyc1();
        rst = 1'b0;
        cyc1();

        check("rst_m_req", bus.m_req, 0);
        check("rst_m_wr", bus.m_wr, 0);
        check("rst_m_size", bus.m_size, 0);
        check("rst_m_addr", bus.m_addr, 0);
        check("rst_m_wdata", bus.m_wdata, 0);
        check("rst_ch_stall", bus.ch_stall, 0);
        check("rst_ch_rdata", bus.ch_rdata, 0);

        // Read on the instruction channel with slow address acceptance.
        single(0, 4'b0000, 32'h1FC0_0000, 32'h0000_0000, 2, 1, 1'b0);
        check("rd0_value", bus.ch_rdata[31:0], 32'hDEAD_BEEF);

        // Same-cycle addr_ok and data_ok: two-cycle latency.
        single(1, 4'b0000, 32'h8000_0100, 32'h1111_1111, 0, 0, 1'b0);

        // Writes of each size; ch_rdata must not move.
        single(1, 4'b0100, 32'h8000_0013, 32'h00AB_0000, 1, 1, 1'b0);
        single(0, 4'b1100, 32'h0000_4003, 32'hCAFE_0000, 0, 2, 1'b0);
        single(0, 4'b0011, 32'h0000_4007, 32'h0000_BABE, 0, 1, 1'b0);
        single(1, 4'b1111, 32'h0000_400B, 32'h0123_4567, 1, 0, 1'b0);
        single(0, 4'b0101, 32'h0000_400E, 32'h7654_3210, 0, 1, 1'b0);
        single(1, 4'b1000, 32'h0000_4010, 32'hEE00_0000, 0, 1, 1'b0);
        single(0, 4'b0001, 32'h0000_4017, 32'h0000_0077, 0, 1, 1'b0);
        single(0, 4'b0000, 32'h0000_501E, 32'h0, 0, 1, 1'b0);

        // Held pipe: done keeps the served channel quiet until the pipe advances.
        hold_stall = 1'b1;
        base = accept_cnt;
        single(0, 4'b0000, 32'h0000_6000, 32'h0, 0, 1, 1'b1);
        repeat (3) begin
            cyc1();
            check("hold_stall_low", bus.ch_stall[0], 0);
        end
        check("hold_reqs", accept_cnt - base, 1);
        hold_stall = 1'b0;
        #1;
        check("hold_release_low", bus.ch_stall[0], 0);
        cyc1();
        check("done_cleared", bus.ch_stall[0], 1);
        bus.ch_en[0] = 1'b0;
        repeat (2) cyc1();
        check("hold_no_reissue", accept_cnt - base, 1);

        // Both channels at once: data channel first, its done holds while inst is served.
        addr_lat = 1;
        data_lat = 1;
        cyc1();
        base = accept_cnt;
        push_access(1, 4'b0000, 32'h0000_7100, 32'hAAAA_0001);
        push_access(0, 4'b0000, 32'h0000_7000, 32'hBBBB_0000);
        seen1 = 1'b0;
        n = 0;
        do begin
            cyc1();
            n++;
            if (seen1) check("dual_done1_hold", bus.ch_stall[1], 0);
            if (!bus.ch_stall[1]) seen1 = 1'b1;
        end while (bus.ch_stall != '0 && n < 60);
        check("dual_stall", bus.ch_stall, 0);
        check("dual_reqs", accept_cnt - base, 2);
        cyc1();
        bus.ch_en = '0;

        // Continuous requests on both channels: four grants alternating 1, 0, 1, 0.
        cyc1();
        base = accept_cnt;
        push_access(1, 4'b0000, 32'h0000_2000, 32'h0);
        push_access(0, 4'b0000, 32'h0000_1000, 32'h0);
        push_access(1, 4'b0000, 32'h0000_2000, 32'h0);
        push_access(0, 4'b0000, 32'h0000_1000, 32'h0);
        n = 0;
        do begin
            cyc1();
            n++;
        end while (!((accept_cnt - base) >= 4 && bus.ch_stall == '0) && n < 100);
        check("alt_reqs", accept_cnt - base, 4);
        check("alt_stall", bus.ch_stall, 0);
        cyc1();
        bus.ch_en = '0;

        // Reset in DATA: request aborted, read data cleared, the held request reissues and completes.
        addr_lat = 0;
        data_lat = 3;
        cyc1();
        push_access(0, 4'b0000, 32'h0000_3000, 32'h0);
        exp_req_q.push_back(exp_req_q[exp_req_q.size() - 1]);
        cyc1();
        cyc1();
        rst = 1'b1;
        for (int i = 0; i < NUM_CH; i++) model_rd[i] = '0;
        cyc1();
        rst = 1'b0;
        check("rstmid_m_req", bus.m_req, 0);
        check("rstmid_stall", bus.ch_stall[0], 1);
        check("rstmid_rdata", bus.ch_rdata, 0);
        check("rstmid_m_addr", bus.m_addr, 0);
        n = 0;
        do begin
            cyc1();
            n++;
        end while (bus.ch_stall[0] && n < 40);
        check("rstmid_latency", n, 5);
        cyc1();
        bus.ch_en = '0;

        repeat (3) cyc1();
        check("end_req_q", exp_req_q.size(), 0);
        check("end_res_q", exp_res_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
